// File: rtl/wrp_shff_rot.sv
// Streaming lane rotator: beat k of each block is rotated across LANES lanes by k
// positions (up, down or bypassed) through a log2(LANES)-stage registered barrel network.
module wrp_shff_rot #(
  parameter int BITWIDTH   = 64,
  parameter int LOG2_LANES = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start_i,
  input  logic                                  vld_i,
  input  logic                                  mode_i,
  input  logic                                  byp_i,
  input  logic [(BITWIDTH<<LOG2_LANES)-1:0]     x_i,
  output logic                                  vld_o,
  output logic [(BITWIDTH<<LOG2_LANES)-1:0]     y_o,
  output logic [LOG2_LANES-1:0]                 beat_o,
  output logic                                  err_o
);

  localparam int L = LOG2_LANES;
  localparam int W = BITWIDTH << LOG2_LANES;
  localparam logic [L-1:0] CNT_ONE = L'(1);

  // Reset release is taken up on one clock edge so the first beat lands on the second edge.
  logic run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  logic take_start;
  logic take_vld;

  assign take_start = run & start_i;
  assign take_vld   = run & vld_i;

  logic [L-1:0] cnt;
  logic         mode_q;
  logic         byp_q;
  logic         err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mode_q <= 1'b0;
      byp_q  <= 1'b0;
      err    <= 1'b0;
    end else if (take_start) begin
      cnt    <= take_vld ? CNT_ONE : '0;
      mode_q <= mode_i;
      byp_q  <= byp_i;
      if (cnt != '0) err <= 1'b1;
    end else if (take_vld) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign err_o = err;

  // The beat coincident with start_i belongs to the new block and uses the new mode.
  logic [L-1:0] k_in;
  logic [L-1:0] sh_in;
  logic         mode_in;
  logic         byp_in;

  assign k_in    = take_start ? '0 : cnt;
  assign mode_in = take_start ? mode_i : mode_q;
  assign byp_in  = take_start ? byp_i : byp_q;
  assign sh_in   = byp_in ? '0 : k_in;

  logic [W-1:0] dat_p   [0:L];
  logic [L-1:0] beat_p  [0:L];
  logic [L-1:0] sh_p    [0:L-1];
  logic [L-1:0] mode_p;
  logic [L:0]   vld_p;
  logic [W-1:0] nxt_dat [0:L-1];

  // Barrel stages: stage s rotates by 2**(L-1-s) lanes, MSB of the shift first.
  for (genvar s = 0; s < L; s++) begin : g_rot
    localparam int SHB = BITWIDTH << (L - 1 - s);
    logic [W-1:0] up;
    logic [W-1:0] dn;
    assign up = {dat_p[s][W-SHB-1:0], dat_p[s][W-1:W-SHB]};
    assign dn = {dat_p[s][SHB-1:0], dat_p[s][W-1:SHB]};
    assign nxt_dat[s] = !sh_p[s][L-1-s] ? dat_p[s] : (mode_p[s] ? dn : up);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p <= '0;
    else        vld_p <= {vld_p[L-1:0], take_vld};
  end

  // Input register (index 0) and stage registers (1..L); data path carries no reset.
  always_ff @(posedge clk) begin
    dat_p[0]  <= x_i;
    beat_p[0] <= k_in;
    sh_p[0]   <= sh_in;
    mode_p[0] <= mode_in;
    for (int s = 0; s < L; s++) begin
      dat_p[s+1]  <= nxt_dat[s];
      beat_p[s+1] <= beat_p[s];
    end
    for (int s = 0; s < L - 1; s++) begin
      sh_p[s+1]   <= sh_p[s];
      mode_p[s+1] <= mode_p[s];
    end
  end

  // Output register: holds the last valid beat while vld_o is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_o  <= 1'b0;
      y_o    <= '0;
      beat_o <= '0;
    end else begin
      vld_o <= vld_p[L];
      if (vld_p[L]) begin
        y_o    <= dat_p[L];
        beat_o <= beat_p[L];
      end
    end
  end

endmodule

// File: tb/tb_wrp_shff_rot.sv
// Directed bench for wrp_shff_rot at 16 lanes x 64 bits; lane n of beat k carries 16*k + n.
module tb_wrp_shff_rot;

  localparam int W = 1024;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic         vld_i;
  logic         mode_i;
  logic         byp_i;
  logic [W-1:0] x_i;
  logic         vld_o;
  logic [W-1:0] y_o;
  logic [3:0]   beat_o;
  logic         err_o;

  wrp_shff_rot #(.BITWIDTH(64), .LOG2_LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .vld_i(vld_i), .mode_i(mode_i),
    .byp_i(byp_i), .x_i(x_i), .vld_o(vld_o), .y_o(y_o), .beat_o(beat_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  bit           st_start [0:63];
  bit           st_vld   [0:63];
  bit           st_mode  [0:63];
  bit           st_byp   [0:63];
  int           st_k     [0:63];
  logic         cap_vld  [0:71];
  logic         cap_err  [0:71];
  logic [W-1:0] cap_y    [0:71];
  logic [3:0]   cap_beat [0:71];

  function automatic logic [W-1:0] mk_x(input int k);
    logic [W-1:0] v;
    for (int j = 0; j < 16; j++) v[j*64 +: 64] = 64'(16 * k + j);
    return v;
  endfunction

  function automatic logic [63:0] exp_lane(input int base, input int rot, input bit dn, input int j);
    int idx;
    idx = dn ? ((j + rot) & 15) : ((j - rot + 16) & 15);
    return 64'(16 * base + idx);
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < 64; c++) begin
      st_start[c] = 1'b0; st_vld[c] = 1'b0; st_mode[c] = 1'b0; st_byp[c] = 1'b0; st_k[c] = 200;
    end
  endtask

  // Drives n stimulus cycles then 8 idle ones; outputs captured each cycle before driving.
  task automatic run_stream(input int n);
    for (int c = 0; c < n + 8; c++) begin
      @(posedge clk); #1;
      cap_vld[c] = vld_o; cap_y[c] = y_o; cap_beat[c] = beat_o; cap_err[c] = err_o;
      if (c < n) begin
        start_i = st_start[c]; vld_i = st_vld[c]; mode_i = st_mode[c];
        byp_i = st_byp[c]; x_i = mk_x(st_k[c]);
      end else begin
        start_i = 1'b0; vld_i = 1'b0; x_i = '0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; vld_i = 1'b0; mode_i = 1'b0; byp_i = 1'b0; x_i = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (vld_o !== 1'b0) $display("FAIL reset_vld got %b want 0", vld_o); else passed++;
    total++; if (y_o !== '0) $display("FAIL reset_y got %h want 0", y_o[63:0]); else passed++;
    total++; if (beat_o !== 4'd0) $display("FAIL reset_beat got %0d want 0", beat_o); else passed++;
    total++; if (err_o !== 1'b0) $display("FAIL reset_err got %b want 0", err_o); else passed++;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_rot_up();
    clear_stim();
    for (int c = 0; c < 16; c++) begin st_vld[c] = 1'b1; st_k[c] = c; end
    st_start[0] = 1'b1;
    run_stream(16);
    for (int c = 0; c < 24; c++) begin
      logic ev;
      ev = (c >= 6) ? st_vld[c-6] : 1'b0;
      total++; if (cap_vld[c] !== ev) $display("FAIL up_vld c=%0d got %b want %b", c, cap_vld[c], ev); else passed++;
      if (ev) begin
        total++; if (cap_beat[c] !== 4'(st_k[c-6])) $display("FAIL up_beat c=%0d got %0d want %0d", c, cap_beat[c], st_k[c-6]); else passed++;
        for (int j = 0; j < 16; j++) begin
          logic [63:0] e;
          e = exp_lane(st_k[c-6], st_k[c-6], 1'b0, j);
          total++; if (cap_y[c][j*64 +: 64] !== e) $display("FAIL up_y c=%0d lane %0d got %0d want %0d", c, j, cap_y[c][j*64 +: 64], e); else passed++;
        end
      end
    end
  endtask

  task automatic test_rot_down();
    clear_stim();
    for (int c = 0; c < 16; c++) begin st_vld[c] = 1'b1; st_k[c] = c; st_mode[c] = 1'b1; end
    st_start[0] = 1'b1;
    run_stream(16);
    for (int c = 0; c < 24; c++) begin
      logic ev;
      ev = (c >= 6) ? st_vld[c-6] : 1'b0;
      total++; if (cap_vld[c] !== ev) $display("FAIL dn_vld c=%0d got %b want %b", c, cap_vld[c], ev); else passed++;
      if (ev) begin
        total++; if (cap_beat[c] !== 4'(st_k[c-6])) $display("FAIL dn_beat c=%0d got %0d want %0d", c, cap_beat[c], st_k[c-6]); else passed++;
        for (int j = 0; j < 16; j++) begin
          logic [63:0] e;
          e = exp_lane(st_k[c-6], st_k[c-6], 1'b1, j);
          total++; if (cap_y[c][j*64 +: 64] !== e) $display("FAIL dn_y c=%0d lane %0d got %0d want %0d", c, j, cap_y[c][j*64 +: 64], e); else passed++;
        end
      end
    end
  endtask

  task automatic test_bypass();
    clear_stim();
    for (int c = 0; c < 16; c++) begin st_vld[c] = 1'b1; st_k[c] = c; st_byp[c] = 1'b1; st_mode[c] = c[0]; end
    st_start[0] = 1'b1;
    run_stream(16);
    for (int c = 0; c < 24; c++) begin
      logic ev;
      ev = (c >= 6) ? st_vld[c-6] : 1'b0;
      total++; if (cap_vld[c] !== ev) $display("FAIL byp_vld c=%0d got %b want %b", c, cap_vld[c], ev); else passed++;
      if (ev) begin
        total++; if (cap_beat[c] !== 4'(st_k[c-6])) $display("FAIL byp_beat c=%0d got %0d want %0d", c, cap_beat[c], st_k[c-6]); else passed++;
        total++; if (cap_y[c] !== mk_x(st_k[c-6])) $display("FAIL byp_y c=%0d lane0 got %0d want %0d", c, cap_y[c][63:0], 16 * st_k[c-6]); else passed++;
      end
    end
    total++; if (cap_err[23] !== 1'b0) $display("FAIL byp_err got %b want 0", cap_err[23]); else passed++;
  endtask

  task automatic test_back_to_back();
    clear_stim();
    for (int c = 0; c < 32; c++) begin st_vld[c] = 1'b1; st_k[c] = c % 16; st_mode[c] = (c >= 16); end
    st_start[0] = 1'b1; st_start[16] = 1'b1;
    run_stream(32);
    for (int c = 0; c < 40; c++) begin
      logic ev;
      ev = (c >= 6) ? st_vld[c-6] : 1'b0;
      total++; if (cap_vld[c] !== ev) $display("FAIL b2b_vld c=%0d got %b want %b", c, cap_vld[c], ev); else passed++;
      if (ev) begin
        total++; if (cap_beat[c] !== 4'(st_k[c-6])) $display("FAIL b2b_beat c=%0d got %0d want %0d", c, cap_beat[c], st_k[c-6]); else passed++;
        for (int j = 0; j < 16; j++) begin
          logic [63:0] e;
          e = exp_lane(st_k[c-6], st_k[c-6], st_mode[c-6], j);
          total++; if (cap_y[c][j*64 +: 64] !== e) $display("FAIL b2b_y c=%0d lane %0d got %0d want %0d", c, j, cap_y[c][j*64 +: 64], e); else passed++;
        end
      end
    end
    total++; if (cap_err[39] !== 1'b0) $display("FAIL b2b_err got %b want 0", cap_err[39]); else passed++;
  endtask

  task automatic test_restart();
    clear_stim();
    for (int c = 0; c < 5; c++) begin st_vld[c] = 1'b1; st_k[c] = c; end
    for (int c = 5; c < 8; c++) begin st_vld[c] = 1'b1; st_k[c] = c - 5; st_mode[c] = 1'b1; end
    st_start[0] = 1'b1; st_start[5] = 1'b1;
    run_stream(8);
    total++; if (cap_err[5] !== 1'b0) $display("FAIL rst_err_pre got %b want 0", cap_err[5]); else passed++;
    total++; if (cap_err[6] !== 1'b1) $display("FAIL rst_err_set got %b want 1", cap_err[6]); else passed++;
    total++; if (cap_err[15] !== 1'b1) $display("FAIL rst_err_sticky got %b want 1", cap_err[15]); else passed++;
    for (int c = 0; c < 16; c++) begin
      logic ev;
      ev = (c >= 6) ? st_vld[c-6] : 1'b0;
      total++; if (cap_vld[c] !== ev) $display("FAIL rs_vld c=%0d got %b want %b", c, cap_vld[c], ev); else passed++;
      if (ev) begin
        total++; if (cap_beat[c] !== 4'(st_k[c-6])) $display("FAIL rs_beat c=%0d got %0d want %0d", c, cap_beat[c], st_k[c-6]); else passed++;
        for (int j = 0; j < 16; j++) begin
          logic [63:0] e;
          e = exp_lane(st_k[c-6], st_k[c-6], st_mode[c-6], j);
          total++; if (cap_y[c][j*64 +: 64] !== e) $display("FAIL rs_y c=%0d lane %0d got %0d want %0d", c, j, cap_y[c][j*64 +: 64], e); else passed++;
        end
      end
    end
  endtask

  task automatic test_gapped();
    clear_stim();
    st_start[0] = 1'b1;
    st_vld[0] = 1'b1; st_k[0] = 0;
    st_vld[3] = 1'b1; st_k[3] = 1;
    st_vld[4] = 1'b1; st_k[4] = 2;
    st_vld[6] = 1'b1; st_k[6] = 3;
    run_stream(7);
    for (int c = 0; c < 15; c++) begin
      logic ev;
      ev = (c >= 6) ? st_vld[c-6] : 1'b0;
      total++; if (cap_vld[c] !== ev) $display("FAIL gap_vld c=%0d got %b want %b", c, cap_vld[c], ev); else passed++;
      if (ev) begin
        total++; if (cap_beat[c] !== 4'(st_k[c-6])) $display("FAIL gap_beat c=%0d got %0d want %0d", c, cap_beat[c], st_k[c-6]); else passed++;
        for (int j = 0; j < 16; j++) begin
          logic [63:0] e;
          e = exp_lane(st_k[c-6], st_k[c-6], 1'b0, j);
          total++; if (cap_y[c][j*64 +: 64] !== e) $display("FAIL gap_y c=%0d lane %0d got %0d want %0d", c, j, cap_y[c][j*64 +: 64], e); else passed++;
        end
      end
    end
  endtask

  task automatic test_arm();
    clear_stim();
    st_start[0] = 1'b1;
    for (int c = 1; c < 4; c++) begin st_vld[c] = 1'b1; st_k[c] = c - 1; end
    for (int c = 0; c < 4; c++) st_mode[c] = 1'b1;
    run_stream(4);
    for (int c = 0; c < 12; c++) begin
      logic ev;
      ev = (c >= 6) ? st_vld[c-6] : 1'b0;
      total++; if (cap_vld[c] !== ev) $display("FAIL arm_vld c=%0d got %b want %b", c, cap_vld[c], ev); else passed++;
      if (ev) begin
        total++; if (cap_beat[c] !== 4'(st_k[c-6])) $display("FAIL arm_beat c=%0d got %0d want %0d", c, cap_beat[c], st_k[c-6]); else passed++;
        for (int j = 0; j < 16; j++) begin
          logic [63:0] e;
          e = exp_lane(st_k[c-6], st_k[c-6], 1'b1, j);
          total++; if (cap_y[c][j*64 +: 64] !== e) $display("FAIL arm_y c=%0d lane %0d got %0d want %0d", c, j, cap_y[c][j*64 +: 64], e); else passed++;
        end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      start_i = (c == 0); vld_i = 1'b1; mode_i = 1'b0; byp_i = 1'b0; x_i = mk_x(c);
    end
    total++; if (vld_o !== 1'b1) $display("FAIL ar_pre_vld got %b want 1", vld_o); else passed++;
    total++; if (err_o !== 1'b1) $display("FAIL ar_pre_err got %b want 1", err_o); else passed++;
    #3 rst_n = 1'b0;
    #1;
    total++; if (vld_o !== 1'b0) $display("FAIL ar_vld got %b want 0", vld_o); else passed++;
    total++; if (y_o !== '0) $display("FAIL ar_y lane0 got %0d want 0", y_o[63:0]); else passed++;
    total++; if (err_o !== 1'b0) $display("FAIL ar_err got %b want 0", err_o); else passed++;
    total++; if (beat_o !== 4'd0) $display("FAIL ar_beat got %0d want 0", beat_o); else passed++;
    start_i = 1'b0; vld_i = 1'b0;
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      total++; if (vld_o !== 1'b0) $display("FAIL ar_stale c=%0d got %b want 0", c, vld_o); else passed++;
    end
    total++; if (err_o !== 1'b0) $display("FAIL ar_err_after got %b want 0", err_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_rot_up();
    test_rot_down();
    test_bypass();
    test_back_to_back();
    test_restart();
    test_gapped();
    test_arm();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout %0d/%0d checks passed at expiry", passed, total);
    $fatal(1, "timeout");
  end

endmodule
